// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out / coefficient-write bundle between the FIR sequencer and its host.
// Signal names keep the sequencer-side direction suffixes so both ends read the same.
interface fir_mac_sequencer_if #(
  parameter int AW = 3
) ();
  logic          coef_we_i;
  logic [AW-1:0] coef_addr_i;
  logic [31:0]   coef_data_i;
  logic          s_valid_i;
  logic [31:0]   s_data_i;
  logic          s_ready_o;
  logic          m_valid_o;
  logic [31:0]   m_data_o;
  logic [2:0]    m_flags_o;
  logic          m_ready_i;

  modport master (
    output coef_we_i, coef_addr_i, coef_data_i, s_valid_i, s_data_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_flags_o
  );

  modport slave (
    input  coef_we_i, coef_addr_i, coef_data_i, s_valid_i, s_data_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_flags_o
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller for a single DSPFP32 MAC tile: issues one tap per cycle,
// waits out the tile pipeline, then presents y[n] with sticky IEEE flags.
module fir_mac_sequencer #(
  parameter int NTAPS       = 8,
  parameter int AW          = 3,
  parameter int MAC_LATENCY = 5,
  parameter int OPM_DELAY   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fir_mac_sequencer_if.slave bus,
  output logic        busy_o,
  output logic [31:0] dsp_x_o,
  output logic [31:0] dsp_h_o,
  output logic        dsp_opm_o,
  output logic        dsp_rst_o,
  input  logic [31:0] dsp_y_i,
  input  logic        dsp_inv_i,
  input  logic        dsp_ovf_i,
  input  logic        dsp_unf_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

  localparam int            CW       = $clog2(NTAPS + MAC_LATENCY + 1);
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);
  localparam logic [CW-1:0] WIN_LO   = CW'(MAC_LATENCY);
  localparam logic [CW-1:0] WIN_HI   = CW'(NTAPS + MAC_LATENCY - 1);
  localparam logic [AW-1:0] PTR_MAX  = AW'(NTAPS - 1);
  localparam logic [AW:0]   NTAPS_W  = (AW+1)'(NTAPS);

  state_e        state_q, state_d;
  logic [31:0]   coef_q [NTAPS];
  logic [31:0]   line_q [NTAPS];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    flag_acc_q, m_flags_q;
  logic [31:0]   m_data_q;

  logic          s_fire, m_fire, coef_ok, in_window, opm_issue, opm_dly;
  logic [2:0]    dsp_flags;
  logic [AW-1:0] tap_idx;

  assign s_fire    = bus.s_valid_i && (state_q == IDLE);
  assign m_fire    = bus.m_ready_i && (state_q == OUT);
  assign coef_ok   = bus.coef_we_i && (state_q == IDLE) && ({1'b0, bus.coef_addr_i} < NTAPS_W);
  assign in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign dsp_flags = {dsp_inv_i, dsp_ovf_i, dsp_unf_i};
  assign tap_idx   = AW'(cnt_q);
  assign opm_issue = (state_q == ISSUE) && (cnt_q != '0);

  // The accumulate bit may need to trail its operands to line up with the tile's opmode stage.
  if (OPM_DELAY == 0) begin : g_opm_direct
    assign opm_dly = opm_issue;
  end else begin : g_opm_delayed
    logic [OPM_DELAY-1:0] opm_pipe_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) opm_pipe_q <= '0;
      else       opm_pipe_q <= (opm_pipe_q << 1) | OPM_DELAY'(opm_issue);
    end
    assign opm_dly = opm_pipe_q[OPM_DELAY-1];
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (s_fire)              state_d = ISSUE;
      ISSUE:   if (cnt_q == LAST_TAP)   state_d = DRAIN;
      DRAIN:   if (cnt_q == WIN_HI)     state_d = OUT;
      OUT:     if (m_fire)              state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Reset is combinationally visible on every output so a mid-run abort is immediate.
  always_comb begin
    bus.s_ready_o = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.m_data_o  = '0;
    bus.m_flags_o = '0;
    busy_o        = 1'b0;
    dsp_x_o       = '0;
    dsp_h_o       = '0;
    dsp_opm_o     = 1'b0;
    dsp_rst_o     = rst_i;
    if (!rst_i) begin
      bus.s_ready_o = (state_q == IDLE);
      bus.m_valid_o = (state_q == OUT);
      bus.m_data_o  = m_data_q;
      bus.m_flags_o = m_flags_q;
      busy_o        = (state_q != IDLE);
      dsp_opm_o     = opm_dly;
      if (state_q == ISSUE) begin
        dsp_x_o = line_q[rp_q];
        dsp_h_o = coef_q[tap_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: coefficient and delay-line storage is reset explicitly because an aborted
      // run must restart from +0.0 history; this keeps these arrays in flops, not RAM.
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
        line_q[i] <= '0;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      flag_acc_q <= '0;
      m_flags_q  <= '0;
      m_data_q   <= '0;
    end else begin
      if (coef_ok) coef_q[bus.coef_addr_i] <= bus.coef_data_i;

      if ((state_q == ISSUE || state_q == DRAIN) && in_window)
        flag_acc_q <= flag_acc_q | dsp_flags;

      unique case (state_q)
        IDLE: begin
          if (s_fire) begin
            line_q[wp_q] <= bus.s_data_i;
            rp_q         <= wp_q;
            cnt_q        <= '0;
            flag_acc_q   <= '0;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + CW'(1);
          rp_q  <= (rp_q == '0) ? PTR_MAX : rp_q - AW'(1);
          if (cnt_q == LAST_TAP) wp_q <= (wp_q == PTR_MAX) ? '0 : wp_q + AW'(1);
        end
        DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == WIN_HI) begin
            m_data_q  <= dsp_y_i;
            m_flags_q <= flag_acc_q | dsp_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with a behavioural binary32 MAC tile in the loop.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 3;
  localparam int AW    = 2;
  localparam int LAT   = 5;

  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F5   = 32'h40A0_0000;
  localparam logic [31:0] F6   = 32'h40C0_0000;
  localparam logic [31:0] F9   = 32'h4110_0000;
  localparam logic [31:0] FMAX = 32'h7F7F_FFFF;
  localparam logic [31:0] FINF = 32'h7F80_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] dsp_x, dsp_h, dsp_y;
  logic        dsp_opm, dsp_rst, dsp_inv, dsp_ovf, dsp_unf;

  int checks = 0;
  int errors = 0;

  fir_mac_sequencer_if #(.AW(AW)) bus ();

  fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW), .MAC_LATENCY(LAT), .OPM_DELAY(0)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy),
    .dsp_x_o(dsp_x), .dsp_h_o(dsp_h), .dsp_opm_o(dsp_opm), .dsp_rst_o(dsp_rst),
    .dsp_y_i(dsp_y), .dsp_inv_i(dsp_inv), .dsp_ovf_i(dsp_ovf), .dsp_unf_i(dsp_unf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural tile: binary32 multiply-accumulate, LAT-cycle pipe
  function automatic real fp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  // {overflow, binary32}; values here are exact so truncation of the mantissa is enough
  function automatic logic [32:0] r2fp(input real v);
    real  a;
    int   e;
    logic s;
    if (v == 0.0) return 33'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e > 127)  return {1'b1, s, 8'hFF, 23'd0};
    if (e < -126) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  real         acc_q;
  logic [31:0] y_pipe [LAT];
  logic [2:0]  f_pipe [LAT];

  always @(posedge clk) begin : tile
    real         p, nacc;
    logic [32:0] enc;
    if (dsp_rst) begin
      acc_q <= 0.0;
      for (int i = 0; i < LAT; i++) begin
        y_pipe[i] <= '0;
        f_pipe[i] <= '0;
      end
    end else begin
      p     = fp2r(dsp_x) * fp2r(dsp_h);
      nacc  = dsp_opm ? acc_q + p : p;
      enc   = r2fp(nacc);
      acc_q <= nacc;
      y_pipe[0] <= enc[31:0];
      f_pipe[0] <= {1'b0, enc[32], 1'b0};
      for (int i = 1; i < LAT; i++) begin
        y_pipe[i] <= y_pipe[i-1];
        f_pipe[i] <= f_pipe[i-1];
      end
    end
  end

  assign dsp_y   = y_pipe[LAT-1];
  assign dsp_inv = f_pipe[LAT-1][2];
  assign dsp_ovf = f_pipe[LAT-1][1];
  assign dsp_unf = f_pipe[LAT-1][0];

  // ---------------- checking helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.coef_we_i   = 1'b1;
    bus.coef_addr_i = a;
    bus.coef_data_i = d;
    @(negedge clk);
    bus.coef_we_i   = 1'b0;
  endtask

  // returns at the falling edge of the first ISSUE cycle (T+1)
  task automatic accept(input logic [31:0] x);
    int n;
    @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = x;
    n = 0;
    while (!bus.s_ready_o && n < 50) begin @(negedge clk); n++; end
    check("s_ready_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.s_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!bus.m_valid_o && lat < 60) begin @(negedge clk); lat++; end
    check("m_valid_wait", 32'(lat < 60), 32'd1);
  endtask

  task automatic take(output logic [31:0] y, output logic [2:0] f);
    y = bus.m_data_o;
    f = bus.m_flags_o;
    bus.m_ready_i = 1'b1;
    @(negedge clk);
    bus.m_ready_i = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] x,
                     input logic [31:0] exp_y, input logic [2:0] exp_f);
    int          lat;
    logic [31:0] y;
    logic [2:0]  f;
    accept(x);
    wait_valid(1, lat);
    take(y, f);
    check({name, "_y"}, y, exp_y);
    check({name, "_flags"}, 32'(f), 32'(exp_f));
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] exp_y;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    int          lat, seen;
    logic [31:0] y, held;
    logic [2:0]  f;

    // h = {1,2,3}: impulse response, then step response crossing the wp wrap
    vecs[0] = '{F1, F1, 3'b000};
    vecs[1] = '{F0, F2, 3'b000};
    vecs[2] = '{F0, F3, 3'b000};
    vecs[3] = '{F0, F0, 3'b000};
    vecs[4] = '{F1, F1, 3'b000};
    vecs[5] = '{F1, 32'h4040_0000, 3'b000};
    vecs[6] = '{F1, F6, 3'b000};
    vecs[7] = '{F1, F6, 3'b000};

    rst = 1'b1;
    bus.coef_we_i = 1'b0; bus.coef_addr_i = '0; bus.coef_data_i = '0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.m_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_dsp_rst", 32'(dsp_rst), 32'd1);
    check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dsp_x", dsp_x, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", 32'(bus.s_ready_o), 32'd1);
    check("idle_dsp_rst", 32'(dsp_rst), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    write_coef(2'd0, F1);
    write_coef(2'd1, F2);
    write_coef(2'd2, F3);

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].x);
      check($sformatf("v%0d_tap0_x", i), dsp_x, vecs[i].x);
      check($sformatf("v%0d_tap0_h", i), dsp_h, F1);
      check($sformatf("v%0d_tap0_opm", i), 32'(dsp_opm), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_tap1_opm", i), 32'(dsp_opm), 32'd1);
      wait_valid(2, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(NTAPS + LAT + 1));
      take(y, f);
      check($sformatf("v%0d_y", i), y, vecs[i].exp_y);
      check($sformatf("v%0d_flags", i), 32'(f), 32'(vecs[i].exp_f));
    end

    // back-pressure: result held for 10 cycles, then one single-cycle transfer
    accept(F1);
    wait_valid(1, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_m_valid", 32'(bus.m_valid_o), 32'd1);
      check("hold_m_data", bus.m_data_o, F6);
      check("hold_s_ready", 32'(bus.s_ready_o), 32'd0);
    end
    take(held, f);
    check("hold_taken", held, F6);
    check("after_take_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("after_take_s_ready", 32'(bus.s_ready_o), 32'd1);

    // writes outside IDLE or out of range must not change h
    accept(F0);
    bus.coef_we_i = 1'b1; bus.coef_addr_i = 2'd0; bus.coef_data_i = F5;
    @(negedge clk);
    bus.coef_we_i = 1'b0;
    wait_valid(2, lat);
    take(y, f);
    check("we_in_issue_y", y, F5);
    write_coef(2'(NTAPS), F9);
    run("oob_a", F0, F3, 3'b000);
    run("oob_b", F1, F1, 3'b000);

    // overflow flag is sticky for one result only
    write_coef(2'd0, FMAX);
    write_coef(2'd1, F0);
    write_coef(2'd2, F0);
    run("ovf", FMAX, FINF, 3'b010);
    run("ovf_next", F1, FMAX, 3'b000);

    // reset while issuing tap 1
    accept(F1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_dsp_rst", 32'(dsp_rst), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dsp_x", dsp_x, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.m_valid_o) seen++;
    end
    check("abort_no_m_valid", 32'(seen), 32'd0);
    check("abort_idle", 32'(bus.s_ready_o), 32'd1);
    write_coef(2'd0, F1);
    write_coef(2'd1, F2);
    write_coef(2'd2, F3);
    run("post_reset_impulse", F1, F1, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
